// File: rtl/mem_stage.sv
// Purpose      : MEM stage of the 5-stage LoongArch pipeline. Completes EXE-issued loads, extends sub-word data, feeds WB.
// Latency      : 1 cycle for ALU/store ops; loads leave in the cycle their SRAM data returns (zero-bubble when it arrives on entry).
// Backpressure : valid/allow_in. Stalls while a load waits for data or WB refuses; returned data is parked while WB is stalled.
//
// Ports:
//   clk, reset                         clock; synchronous active-high reset
//   exe_to_mem_bus/_valid, mem_allow_in   EXE -> MEM payload handshake
//   mem_to_wb_bus/_valid, wb_allow_in     MEM -> WB payload handshake
//   data_sram_rvalid/_rdata            one-cycle load-data return from the data SRAM
//   mem_fwd_bus                        {fwd_valid, dest, final_result} bypass to ID
//   mem_load_pending                   load in MEM still waiting for data (ID stalls)

module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [73:0] exe_to_mem_bus,
    input  logic        exe_to_mem_valid,
    output logic        mem_allow_in,
    input  logic        wb_allow_in,
    output logic        mem_to_wb_valid,
    output logic [69:0] mem_to_wb_bus,
    input  logic        data_sram_rvalid,
    input  logic [31:0] data_sram_rdata,
    output logic [37:0] mem_fwd_bus,
    output logic        mem_load_pending
);

    typedef struct packed {
        logic [31:0] alu_result;
        logic [2:0]  ld_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] pc;
    } exe_to_mem_t;

    typedef enum logic [1:0] {
        IDLE,   // no load outstanding
        WAIT,   // load in MEM, data not yet returned
        HOLD    // data parked in rdata_buf, WB stalled
    } state_t;

    exe_to_mem_t exe_in;
    exe_to_mem_t mem_r;
    state_t      state;
    state_t      state_nxt;
    logic        mem_valid;
    logic        ready_go;
    logic        rdata_buf_valid;
    logic [31:0] rdata_buf;
    logic        capture;
    logic        fwd_valid;
    logic [31:0] word;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;
    logic [31:0] final_result;

    assign exe_in = exe_to_mem_bus;

    // Data arriving this cycle completes the load combinationally.
    assign ready_go        = !mem_r.res_from_mem | rdata_buf_valid | data_sram_rvalid;
    assign mem_allow_in    = !mem_valid | (ready_go & wb_allow_in);
    assign mem_to_wb_valid = mem_valid & ready_go;

    // Returned data has to be parked only when WB refuses it; in WAIT with
    // rvalid, mem_allow_in collapses to wb_allow_in. Rvalid outside WAIT is stray.
    assign capture = (state == WAIT) & data_sram_rvalid & !mem_allow_in;

    always_comb begin
        state_nxt = state;
        if (mem_allow_in) begin
            // Whatever currently sits in MEM leaves (or MEM is empty), so the
            // state follows the incoming instruction.
            state_nxt = (exe_to_mem_valid & exe_in.res_from_mem) ? WAIT : IDLE;
        end else if (capture) begin
            state_nxt = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            mem_valid       <= 1'b0;
            rdata_buf_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (mem_allow_in) begin
                mem_valid <= exe_to_mem_valid;
            end
            if (mem_allow_in) begin
                rdata_buf_valid <= 1'b0;
            end else if (capture) begin
                rdata_buf_valid <= 1'b1;
            end
        end
    end

    // Payload registers are don't-care while invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (exe_to_mem_valid & mem_allow_in) begin
            mem_r <= exe_in;
        end
        if (capture) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    // Sub-word extraction
    assign word    = rdata_buf_valid ? rdata_buf : data_sram_rdata;
    assign off     = mem_r.alu_result[1:0];
    assign ld_byte = word[{off, 3'b000} +: 8];
    assign ld_half = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        ld_result = word;
        case (mem_r.ld_op)
            3'b001:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            3'b101:  ld_result = {24'h0, ld_byte};
            3'b010:  ld_result = {{16{ld_half[15]}}, ld_half};
            3'b110:  ld_result = {16'h0, ld_half};
            default: ld_result = word;
        endcase
    end

    assign final_result  = mem_r.res_from_mem ? ld_result : mem_r.alu_result;
    assign mem_to_wb_bus = {final_result, mem_r.gr_we, mem_r.dest, mem_r.pc};

    assign fwd_valid        = mem_valid & mem_r.gr_we & (mem_r.dest != 5'd0) & ready_go;
    assign mem_fwd_bus      = {fwd_valid, mem_r.dest, final_result};
    assign mem_load_pending = mem_valid & mem_r.res_from_mem & !ready_go;

endmodule
